buzzer_lockout_arbiter: RTL



---
 rtl/buzz_pkg.sv | 13 +
 rtl/buzz_sync.sv | 30 +++
 rtl/buzzer_lockout_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/buzz_pkg.sv
// Shared types for the buzzer lockout arbiter: round state encoding.
package buzz_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_LOCKED  = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_t;

endpackage

// File: rtl/buzz_sync.sv
// Vector synchroniser for active-low buttons plus registered falling-edge (press) detector.
module buzz_sync #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_n,
   output logic [WIDTH-1:0] press_evt
);

   logic [STAGES-1:0][WIDTH-1:0] stage_q;
   logic [STAGES-1:0]            flush_q;

   // flush_q marks stages holding real samples; a button held through reset
   // must not look like a fresh press once the released reset values drain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_q   <= '1;
         flush_q   <= '0;
         press_evt <= '0;
      end else begin
         stage_q   <= {stage_q[STAGES-2:0], raw_n};
         flush_q   <= {flush_q[STAGES-2:0], 1'b1};
         press_evt <= flush_q[STAGES-1] ? (stage_q[STAGES-1] & ~stage_q[STAGES-2])
                                        : WIDTH'(0);
      end
   end

endmodule

// File: rtl/buzzer_lockout_arbiter.sv
// Fastest-finger-first arbiter: latches the first press after arm, locks out others, times the answer.
module buzzer_lockout_arbiter
   import buzz_pkg::*;
#(
   parameter int unsigned N_CH          = 8,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned ANSWER_CYCLES = 1000,
   parameter int unsigned IDX_W         = $clog2(N_CH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_CH-1:0]    buzz_n,
   input  logic               arm,
   input  logic               clear,
   output logic [STATE_W-1:0] state,
   output logic               winner_valid,
   output logic [IDX_W-1:0]   winner_idx,
   output logic [N_CH-1:0]    winner_onehot,
   output logic               tie,
   output logic               timeout
);

   localparam int unsigned CNT_W    = $clog2(N_CH + 1);
   localparam int unsigned TMR_W    = (ANSWER_CYCLES > 0) ? $clog2(ANSWER_CYCLES + 1) : 1;
   localparam int unsigned TMR_LOAD = (ANSWER_CYCLES > 0) ? ANSWER_CYCLES - 1 : 0;

   state_t            state_q;
   logic [TMR_W-1:0]  timer_q;
   logic [N_CH-1:0]   press_evt;
   logic [IDX_W-1:0]  sel_idx_c;
   logic [CNT_W-1:0]  hits_c;
   logic              multi_c;

   buzz_sync #(
      .WIDTH  (N_CH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .raw_n     (buzz_n),
      .press_evt (press_evt)
   );

   // Highest index wins; later iterations override earlier ones.
   always_comb begin
      sel_idx_c = '0;
      hits_c    = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (press_evt[i]) begin
            sel_idx_c = IDX_W'(i);
            hits_c    = hits_c + CNT_W'(1);
         end
      end
      multi_c = (hits_c > CNT_W'(1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         winner_valid  <= 1'b0;
         winner_idx    <= '0;
         winner_onehot <= '0;
         tie           <= 1'b0;
         timeout       <= 1'b0;
      end else if (clear) begin
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         winner_valid  <= 1'b0;
         winner_idx    <= '0;
         winner_onehot <= '0;
         tie           <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arm) state_q <= ST_ARMED;
            end
            ST_ARMED: begin
               if (|press_evt) begin
                  state_q       <= ST_LOCKED;
                  winner_valid  <= 1'b1;
                  winner_idx    <= sel_idx_c;
                  winner_onehot <= N_CH'(1) << sel_idx_c;
                  tie           <= multi_c;
                  timer_q       <= TMR_W'(TMR_LOAD);
               end
            end
            ST_LOCKED: begin
               // A zero-length window means no timer: hold until the host clears.
               if (ANSWER_CYCLES != 0) begin
                  if (timer_q == '0) begin
                     state_q <= ST_TIMEOUT;
                     timeout <= 1'b1;
                  end else begin
                     timer_q <= timer_q - TMR_W'(1);
                  end
               end
            end
            ST_TIMEOUT: begin
               state_q <= ST_TIMEOUT;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign state = state_q;

endmodule
